alu_issue_ctrl: RTL and testbench

Issue and writeback controller that drives the 19-bit ALU from the operand side. It accepts 19-bit instruction words over a valid/ready handshake and reads two source operands from an internal 8x19 register file. It presents opcode and operands to the ALU, samples the ALU's result and zero outputs, then writes the result back to the register file. It sits between the instruction source and the ALU datapath in the 19-bit processor.

---
 rtl/alu_issue_ctrl.sv | 172 +++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module : alu_issue_ctrl
// Issue/writeback controller for the 19-bit ALU with an internal 8x19 regfile.
// Build option ALU_ISSUE_R0_ZERO_EN: register 0 reads as zero, writes dropped.
// Rev    : 1.0  initial release
// ============================================================================
module alu_issue_ctrl #(
   parameter int WIDTH       = 19,
   parameter int ALU_LATENCY = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instr_valid,
   input  logic [WIDTH-1:0] instr,
   output logic             instr_ready,
   output logic [3:0]       alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic             done,
   output logic             zero_flag,
   output logic             illegal_op,
   output logic             div0,
   input  logic [2:0]       dbg_addr,
   output logic [WIDTH-1:0] dbg_data
);

   localparam logic [3:0] c_op_div   = 4'h3;
   localparam logic [3:0] c_op_inc   = 4'h4;
   localparam logic [3:0] c_op_dec   = 4'h5;
   localparam logic [3:0] c_op_not   = 4'h9;
   localparam logic [3:0] c_op_max   = 4'h9;
   localparam logic [3:0] c_lat_last = 4'(ALU_LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      EXEC = 2'd2,
      WB   = 2'd3
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_regs [8];
   logic [3:0]       r_op;
   logic [2:0]       r_rd;
   logic [2:0]       r_rs1;
   logic [2:0]       r_rs2;
   logic [3:0]       r_cnt;
   logic [WIDTH-1:0] r_result;
   logic             r_wr_en;
   logic             r_zero;

   logic [WIDTH-1:0] w_src_a;
   logic [WIDTH-1:0] w_src_b;
   logic             w_illegal;
   logic             w_unary;
   logic             w_div0;
   logic             w_rd_blocked;
   logic             w_unused;

   // Low instruction bits are reserved and deliberately ignored.
   assign w_unused = ^instr[WIDTH-14:0];

   always_comb begin
      w_src_a  = r_regs[r_rs1];
      w_src_b  = r_regs[r_rs2];
      dbg_data = r_regs[dbg_addr];
`ifdef ALU_ISSUE_R0_ZERO_EN
      if (r_rs1 == 3'd0) w_src_a = '0;
      if (r_rs2 == 3'd0) w_src_b = '0;
      if (dbg_addr == 3'd0) dbg_data = '0;
`endif
   end

`ifdef ALU_ISSUE_R0_ZERO_EN
   assign w_rd_blocked = (r_rd == 3'd0);
`else
   assign w_rd_blocked = 1'b0;
`endif

   assign w_illegal = (r_op > c_op_max);
   assign w_unary   = (r_op == c_op_inc) || (r_op == c_op_dec) || (r_op == c_op_not);
   assign w_div0    = (r_op == c_op_div) && (w_src_b == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         instr_ready <= 1'b1;
         done        <= 1'b0;
         illegal_op  <= 1'b0;
         div0        <= 1'b0;
         zero_flag   <= 1'b0;
         alu_op      <= '0;
         alu_a       <= '0;
         alu_b       <= '0;
         r_op        <= '0;
         r_rd        <= '0;
         r_rs1       <= '0;
         r_rs2       <= '0;
         r_cnt       <= '0;
         r_result    <= '0;
         r_wr_en     <= 1'b0;
         r_zero      <= 1'b0;
         for (int i = 0; i < 8; i++) r_regs[i] <= '0;
      end else begin
         done       <= 1'b0;
         illegal_op <= 1'b0;
         div0       <= 1'b0;
         case (r_state)
            IDLE: begin
               if (instr_valid) begin
                  r_op        <= instr[WIDTH-1 -: 4];
                  r_rd        <= instr[WIDTH-5 -: 3];
                  r_rs1       <= instr[WIDTH-8 -: 3];
                  r_rs2       <= instr[WIDTH-11 -: 3];
                  instr_ready <= 1'b0;
                  r_state     <= READ;
               end
            end
            READ: begin
               if (w_illegal) begin
                  r_wr_en    <= 1'b0;
                  done       <= 1'b1;
                  illegal_op <= 1'b1;
                  r_state    <= WB;
               end else if (w_div0) begin
                  // Saturated quotient, ALU never sees this instruction.
                  r_wr_en  <= 1'b1;
                  r_result <= '1;
                  r_zero   <= 1'b0;
                  done     <= 1'b1;
                  div0     <= 1'b1;
                  r_state  <= WB;
               end else begin
                  alu_op  <= r_op;
                  alu_a   <= w_src_a;
                  alu_b   <= w_unary ? '0 : w_src_b;
                  r_cnt   <= c_lat_last;
                  r_state <= EXEC;
               end
            end
            EXEC: begin
               if (r_cnt == 4'd0) begin
                  r_result <= alu_result;
                  r_zero   <= alu_zero;
                  r_wr_en  <= 1'b1;
                  done     <= 1'b1;
                  r_state  <= WB;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            WB: begin
               if (r_wr_en) begin
                  zero_flag <= r_zero;
                  if (!w_rd_blocked) r_regs[r_rd] <= r_result;
               end
               instr_ready <= 1'b1;
               r_state     <= IDLE;
            end
            default: begin
               instr_ready <= 1'b1;
               r_state     <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// Self-checking bench for alu_issue_ctrl: behavioural ALU, architectural
// register model and an expected-result queue checked at each retirement.
module tb_alu_issue_ctrl;

   localparam int WIDTH = 19;
   localparam int LAT   = 1;
   localparam int LAT3  = 3;

   logic             clk;
   logic             rst;
   logic             instr_valid;
   logic [WIDTH-1:0] instr;
   logic             instr_ready;
   logic [3:0]       alu_op;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_result;
   logic             alu_zero;
   logic             done;
   logic             zero_flag;
   logic             illegal_op;
   logic             div0;
   logic [2:0]       dbg_addr;
   logic [WIDTH-1:0] dbg_data;

   logic             instr_valid3;
   logic [WIDTH-1:0] instr3;
   logic             instr_ready3;
   logic [3:0]       alu_op3;
   logic [WIDTH-1:0] alu_a3;
   logic [WIDTH-1:0] alu_b3;
   logic [WIDTH-1:0] alu_result3;
   logic             alu_zero3;
   logic             done3;
   logic             zero_flag3;
   logic             illegal_op3;
   logic             div0_3;
   logic [2:0]       dbg_addr3;
   logic [WIDTH-1:0] dbg_data3;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct packed {
      logic [2:0]       rd;
      logic [WIDTH-1:0] old;
      logic [WIDTH-1:0] new_val;
      logic             ill;
      logic             dz;
      logic             zf;
      logic [7:0]       lat;
   } exp_t;

   exp_t             sb[$];
   logic [WIDTH-1:0] q3[$];
   logic [WIDTH-1:0] mdl [8];
   logic             mdl_zero;

   function automatic logic [WIDTH-1:0] alu_model(input logic [3:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
      case (op)
         4'h0: return a + b;
         4'h1: return a - b;
         4'h2: return a * b;
         4'h3: return (b == '0) ? '1 : a / b;
         4'h4: return a + 19'd1;
         4'h5: return a - 19'd1;
         4'h6: return a & b;
         4'h7: return a | b;
         4'h8: return a ^ b;
         4'h9: return ~a;
         default: return '0;
      endcase
   endfunction

   function automatic logic [WIDTH-1:0] rdreg(input logic [2:0] addr);
`ifdef ALU_ISSUE_R0_ZERO_EN
      if (addr == 3'd0) return '0;
`endif
      return mdl[addr];
   endfunction

   function automatic logic r0_blocked(input logic [2:0] addr);
`ifdef ALU_ISSUE_R0_ZERO_EN
      return addr == 3'd0;
`else
      return addr != addr;
`endif
   endfunction

   assign alu_result  = alu_model(alu_op, alu_a, alu_b);
   assign alu_zero    = (alu_result == '0);
   assign alu_result3 = alu_model(alu_op3, alu_a3, alu_b3);
   assign alu_zero3   = (alu_result3 == '0);

   alu_issue_ctrl #(.WIDTH(WIDTH), .ALU_LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_zero(alu_zero), .done(done),
      .zero_flag(zero_flag), .illegal_op(illegal_op), .div0(div0),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   alu_issue_ctrl #(.WIDTH(WIDTH), .ALU_LATENCY(LAT3)) dut3 (
      .clk(clk), .rst(rst), .instr_valid(instr_valid3), .instr(instr3),
      .instr_ready(instr_ready3), .alu_op(alu_op3), .alu_a(alu_a3), .alu_b(alu_b3),
      .alu_result(alu_result3), .alu_zero(alu_zero3), .done(done3),
      .zero_flag(zero_flag3), .illegal_op(illegal_op3), .div0(div0_3),
      .dbg_addr(dbg_addr3), .dbg_data(dbg_data3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      instr_valid = 1'b0;
      instr_valid3 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) mdl[i] = '0;
      mdl_zero = 1'b0;
   endtask

   // Issue one instruction on the LAT=1 instance and check its retirement.
   task automatic run_instr(input logic [3:0] op, input logic [2:0] rd,
                            input logic [2:0] rs1, input logic [2:0] rs2);
      exp_t             e;
      exp_t             g;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] v;
      int               edges;
      int               n;
      a = rdreg(rs1);
      b = (op == 4'h4 || op == 4'h5 || op == 4'h9) ? '0 : rdreg(rs2);
      e.rd  = rd;
      e.old = rdreg(rd);
      e.ill = (op > 4'h9);
      e.dz  = !e.ill && (op == 4'h3) && (b == '0);
      v     = e.dz ? '1 : alu_model(op, a, b);
      e.zf  = e.ill ? mdl_zero : (e.dz ? 1'b0 : (v == '0));
      e.lat = (e.ill || e.dz) ? 8'd2 : 8'(LAT + 2);
      if (!e.ill && !r0_blocked(rd)) mdl[rd] = v;
      mdl_zero  = e.zf;
      e.new_val = rdreg(rd);
      sb.push_back(e);

      @(negedge clk);
      instr       = {op, rd, rs1, rs2, 6'h2A};
      instr_valid = 1'b1;
      dbg_addr    = rd;
      n = 0;
      while (!instr_ready && n < 50) begin @(negedge clk); n++; end
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      edges = 1;
      while (!done && edges < 40) begin @(negedge clk); edges++; end
      g = sb.pop_front();
      n_total++;
      if (done !== 1'b1) $display("FAIL done_arrives op=%h rd=%0d: got %b expected 1", op, rd, done);
      else n_pass++;
      n_total++;
      if (edges != int'(g.lat)) $display("FAIL latency op=%h rd=%0d: got %0d expected %0d", op, rd, edges, g.lat);
      else n_pass++;
      n_total++;
      if (illegal_op !== g.ill) $display("FAIL illegal_op op=%h: got %b expected %b", op, illegal_op, g.ill);
      else n_pass++;
      n_total++;
      if (div0 !== g.dz) $display("FAIL div0 op=%h: got %b expected %b", op, div0, g.dz);
      else n_pass++;
      n_total++;
      if (dbg_data !== g.old) $display("FAIL prewrite_r%0d op=%h: got %h expected %h", g.rd, op, dbg_data, g.old);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (done !== 1'b0) $display("FAIL done_single_pulse op=%h: got %b expected 0", op, done);
      else n_pass++;
      n_total++;
      if (dbg_data !== g.new_val) $display("FAIL result_r%0d op=%h: got %h expected %h", g.rd, op, dbg_data, g.new_val);
      else n_pass++;
      n_total++;
      if (zero_flag !== g.zf) $display("FAIL zero_flag op=%h: got %b expected %b", op, zero_flag, g.zf);
      else n_pass++;
   endtask

   task automatic test_reset();
      apply_reset();
      n_total++;
      if ({instr_ready, done, illegal_op, div0, zero_flag} !== 5'b10000)
         $display("FAIL reset_flags: got %b expected 10000", {instr_ready, done, illegal_op, div0, zero_flag});
      else n_pass++;
      n_total++;
      if ({alu_op, alu_a, alu_b} !== '0)
         $display("FAIL reset_alu_inputs: got %h/%h/%h expected 0/0/0", alu_op, alu_a, alu_b);
      else n_pass++;
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         #1;
         n_total++;
         if (dbg_data !== '0) $display("FAIL reset_r%0d: got %h expected 0", i, dbg_data);
         else n_pass++;
      end
      n_total++;
      if ({instr_ready3, done3} !== 2'b10) $display("FAIL reset_lat3: got %b expected 10", {instr_ready3, done3});
      else n_pass++;
   endtask

   task automatic test_inc_dec();
      run_instr(4'h5, 3'd1, 3'd0, 3'd0);   // R1 = 0 - 1
      run_instr(4'h4, 3'd2, 3'd1, 3'd0);   // R2 = R1 + 1 wraps to 0
   endtask

   task automatic test_arith();
      run_instr(4'h4, 3'd1, 3'd2, 3'd0);
      for (int i = 0; i < 9; i++) run_instr(4'h4, 3'd1, 3'd1, 3'd0);
      for (int i = 0; i < 5; i++) run_instr(4'h4, 3'd2, 3'd2, 3'd0);
      run_instr(4'h1, 3'd3, 3'd1, 3'd2);   // 10 - 5
      run_instr(4'h2, 3'd4, 3'd3, 3'd3);   // 5 * 5
      run_instr(4'h0, 3'd7, 3'd1, 3'd2);
      run_instr(4'h3, 3'd5, 3'd4, 3'd2);
      run_instr(4'h6, 3'd7, 3'd1, 3'd2);   // 10 & 5 == 0
      run_instr(4'h7, 3'd7, 3'd1, 3'd2);
      run_instr(4'h8, 3'd7, 3'd7, 3'd4);
      run_instr(4'h9, 3'd5, 3'd1, 3'd3);
      run_instr(4'h1, 3'd7, 3'd2, 3'd1);   // 5 - 10 wraps
   endtask

   task automatic test_div0();
      logic [3:0]       op_before;
      logic [WIDTH-1:0] a_before;
      op_before = alu_op;
      a_before  = alu_a;
      run_instr(4'h3, 3'd5, 3'd4, 3'd6);
      n_total++;
      if (alu_op !== op_before || alu_a !== a_before)
         $display("FAIL div0_alu_untouched: got %h/%h expected %h/%h", alu_op, alu_a, op_before, a_before);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] r3_before;
      logic [WIDTH-1:0] r6_old;
      logic [WIDTH-1:0] r6_new;
      logic             zf_before;
      logic             ill_seen;
      int               low_cnt;
      int               done_cnt;
      int               edges;
      r3_before = rdreg(3'd3);
      zf_before = mdl_zero;
      r6_old    = rdreg(3'd6);
      r6_new    = alu_model(4'h4, r6_old, '0);
      @(negedge clk);
      instr       = {4'hC, 3'd3, 3'd1, 3'd2, 6'd0};
      instr_valid = 1'b1;
      dbg_addr    = 3'd3;
      @(posedge clk);
      @(negedge clk);
      instr    = {4'h4, 3'd6, 3'd6, 3'd0, 6'd0};
      low_cnt  = 0;
      done_cnt = 0;
      ill_seen = 1'b0;
      while (!instr_ready && low_cnt < 20) begin
         if (done) done_cnt++;
         ill_seen = ill_seen | illegal_op;
         low_cnt++;
         @(negedge clk);
      end
      n_total++;
      if (low_cnt != 2) $display("FAIL b2b_holdoff_cycles: got %0d expected 2", low_cnt);
      else n_pass++;
      n_total++;
      if (done_cnt != 1 || !ill_seen) $display("FAIL illegal_retire: got done=%0d ill=%b expected 1/1", done_cnt, ill_seen);
      else n_pass++;
      n_total++;
      if (dbg_data !== r3_before || zero_flag !== zf_before)
         $display("FAIL illegal_no_write: got %h/%b expected %h/%b", dbg_data, zero_flag, r3_before, zf_before);
      else n_pass++;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      dbg_addr    = 3'd6;
      edges = 1;
      while (!done && edges < 40) begin @(negedge clk); edges++; end
      n_total++;
      if (edges != LAT + 2 || dbg_data !== r6_old)
         $display("FAIL b2b_second_retire: got %0d/%h expected %0d/%h", edges, dbg_data, LAT + 2, r6_old);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (dbg_data !== r6_new || zero_flag !== 1'b0)
         $display("FAIL b2b_second_result: got %h/%b expected %h/0", dbg_data, zero_flag, r6_new);
      else n_pass++;
      mdl[6]   = r6_new;
      mdl_zero = 1'b0;
   endtask

   task automatic test_abort();
      int done_cnt;
      @(negedge clk);
      instr       = {4'h0, 3'd7, 3'd1, 3'd2, 6'd0};
      instr_valid = 1'b1;
      dbg_addr    = 3'd7;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      done_cnt = done ? 1 : 0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) mdl[i] = '0;
      mdl_zero = 1'b0;
      n_total++;
      if (instr_ready !== 1'b1) $display("FAIL abort_ready: got %b expected 1", instr_ready);
      else n_pass++;
      n_total++;
      if (alu_op !== 4'h0 || alu_a !== '0) $display("FAIL abort_alu_reset: got %h/%h expected 0/0", alu_op, alu_a);
      else n_pass++;
      for (int i = 0; i < 5; i++) begin
         if (done) done_cnt++;
         @(negedge clk);
      end
      n_total++;
      if (done_cnt != 0) $display("FAIL abort_no_done: got %0d expected 0", done_cnt);
      else n_pass++;
      n_total++;
      if (dbg_data !== '0) $display("FAIL abort_r7: got %h expected 0", dbg_data);
      else n_pass++;
   endtask

   task automatic test_r0();
      logic [WIDTH-1:0] r0_exp;
`ifdef ALU_ISSUE_R0_ZERO_EN
      r0_exp = '0;
`else
      r0_exp = 19'd1;
`endif
      run_instr(4'h4, 3'd0, 3'd0, 3'd0);
      dbg_addr = 3'd0;
      #1;
      n_total++;
      if (dbg_data !== r0_exp || zero_flag !== 1'b0)
         $display("FAIL r0_behaviour: got %h/%b expected %h/0", dbg_data, zero_flag, r0_exp);
      else n_pass++;
   endtask

   task automatic test_latency3();
      logic [WIDTH-1:0] ins [3];
      logic [WIDTH-1:0] ev  [3];
      logic [WIDTH-1:0] cur;
      logic [WIDTH-1:0] got;
      int               edges;
      int               n;
      ins[0] = {4'h4, 3'd1, 3'd1, 3'd0, 6'd0}; ev[0] = 19'd1;
      ins[1] = {4'h4, 3'd1, 3'd1, 3'd0, 6'd0}; ev[1] = 19'd2;
      ins[2] = {4'h2, 3'd2, 3'd1, 3'd1, 6'd0}; ev[2] = 19'd4;
      for (int i = 0; i < 3; i++) begin
         q3.push_back(ev[i]);
         cur = ins[i];
         @(negedge clk);
         instr3       = cur;
         instr_valid3 = 1'b1;
         dbg_addr3    = cur[14:12];
         n = 0;
         while (!instr_ready3 && n < 50) begin @(negedge clk); n++; end
         @(posedge clk);
         @(negedge clk);
         instr_valid3 = 1'b0;
         edges = 1;
         while (!done3 && edges < 60) begin @(negedge clk); edges++; end
         n_total++;
         if (edges != LAT3 + 2) $display("FAIL lat3_latency[%0d]: got %0d expected %0d", i, edges, LAT3 + 2);
         else n_pass++;
         @(negedge clk);
         got = q3.pop_front();
         n_total++;
         if (dbg_data3 !== got) $display("FAIL lat3_result[%0d]: got %h expected %h", i, dbg_data3, got);
         else n_pass++;
      end
   endtask

   initial begin
      rst          = 1'b1;
      instr_valid  = 1'b0;
      instr        = '0;
      dbg_addr     = '0;
      instr_valid3 = 1'b0;
      instr3       = '0;
      dbg_addr3    = '0;
      test_reset();
      test_inc_dec();
      test_arith();
      test_div0();
      test_back_to_back();
      test_abort();
      test_r0();
      test_latency3();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
